// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the DAQ reset sequencer slice.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        ASSERT  = 2'd3
    } seq_state_t;

    localparam int unsigned DEF_NUM_STAGES = 3;
    localparam int unsigned DEF_STAGE_DLY  = 16;
    localparam int unsigned DEF_LOCK_FILT  = 8;
    localparam int unsigned DEF_WDOG_CYC   = 65535;

    // Width large enough to hold the largest terminal count without wrapping.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Reset-distribution bus: lock/request inputs in, per-domain resets and status out.
interface reset_sequencer_if
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES
);
    logic                  pll_locked;
    logic                  soft_rst_req;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  all_ready;
    logic                  busy;
    logic                  wdog_timeout;

    modport master (
        input  pll_locked,
        input  soft_rst_req,
        output stage_rst_n,
        output all_ready,
        output busy,
        output wdog_timeout
    );

    modport slave (
        output pll_locked,
        output soft_rst_req,
        input  stage_rst_n,
        input  all_ready,
        input  busy,
        input  wdog_timeout
    );
endinterface

// File: rtl/reset_sequencer_bit_sync.sv
// Two-flop synchroniser with asynchronous active-low reset to 0.
module bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release for the ADC->FIFO->UDP chain, gated by a filtered PLL lock.
// Optional HOLD watchdog is built only when RSTSEQ_WDOG_EN is defined.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
    parameter int unsigned STAGE_DLY  = DEF_STAGE_DLY,
    parameter int unsigned LOCK_FILT  = DEF_LOCK_FILT,
    parameter int unsigned WDOG_CYC   = DEF_WDOG_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    reset_sequencer_if.master bus
);
    localparam int unsigned CW = cnt_width(STAGE_DLY, LOCK_FILT, WDOG_CYC);
    localparam int unsigned IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0] DLY_LAST  = CW'(STAGE_DLY - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

    seq_state_t            state;
    logic [CW-1:0]         filt_cnt;
    logic [CW-1:0]         dly_cnt;
    logic [IW-1:0]         idx;
    logic [NUM_STAGES-1:0] stage_q;
    logic                  all_ready_q;
    logic                  busy_q;
    logic                  lock_s;
    logic                  exit_req;
    logic                  enter_run;

    bit_sync u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (lock_s)
    );

    // Exit has priority over a coincident release, so the last stage never sneaks out.
    assign exit_req  = !lock_s || bus.soft_rst_req;
    assign enter_run = (state == RELEASE) && !exit_req &&
                       (dly_cnt == DLY_LAST) && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HOLD;
            filt_cnt    <= '0;
            dly_cnt     <= '0;
            idx         <= '0;
            stage_q     <= '0;
            all_ready_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            unique case (state)
                HOLD: begin
                    if (bus.soft_rst_req || !lock_s) begin
                        filt_cnt <= '0;
                    end else if (filt_cnt == FILT_LAST) begin
                        state    <= RELEASE;
                        filt_cnt <= '0;
                        dly_cnt  <= '0;
                        idx      <= '0;
                    end else begin
                        filt_cnt <= filt_cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (exit_req) begin
                        state       <= ASSERT;
                        stage_q     <= '0;
                        all_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end else if (dly_cnt == DLY_LAST) begin
                        stage_q[idx] <= 1'b1;
                        dly_cnt      <= '0;
                        if (idx == IDX_LAST) begin
                            state <= RUN;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        dly_cnt <= dly_cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (exit_req) begin
                        state       <= ASSERT;
                        stage_q     <= '0;
                        all_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        all_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                ASSERT: begin
                    state       <= HOLD;
                    stage_q     <= '0;
                    filt_cnt    <= '0;
                    dly_cnt     <= '0;
                    idx         <= '0;
                    all_ready_q <= 1'b0;
                    busy_q      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.stage_rst_n = stage_q;
    assign bus.all_ready   = all_ready_q;
    assign bus.busy        = busy_q;

`ifdef RSTSEQ_WDOG_EN
    localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_CYC - 1);

    logic [CW-1:0] wdog_cnt;
    logic          wdog_q;

    // Counts only while waiting for lock; flag survives until reset or a successful RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            wdog_q   <= 1'b0;
        end else begin
            if (state == HOLD) begin
                if (wdog_cnt != '1) wdog_cnt <= wdog_cnt + CW'(1);
                if (wdog_cnt == WDOG_LAST) wdog_q <= 1'b1;
            end else begin
                wdog_cnt <= '0;
            end
            if (enter_run) wdog_q <= 1'b0;
        end
    end

    assign bus.wdog_timeout = wdog_q;
`else
    assign bus.wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench: elapsed-time reference model plus directed timing pins and random stress.
module tb_reset_sequencer;
    localparam int NS = 3;
    localparam int SD = 16;
    localparam int LF = 8;
    localparam int WC = 100;
`ifdef RSTSEQ_WDOG_EN
    localparam int WD_EXP_T = 100;
`else
    localparam int WD_EXP_T = -1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

    reset_sequencer #(
        .NUM_STAGES (NS),
        .STAGE_DLY  (SD),
        .LOCK_FILT  (LF),
        .WDOG_CYC   (WC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: phase flags plus elapsed cycles since sequencing began.
    bit ms1, ms2, m_ls, m_soft;
    bit m_wait, m_gap, m_wdog;
    int m_t, m_streak, m_hold_edges;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms1 = 0; ms2 = 0;
            m_wait = 1; m_gap = 0; m_wdog = 0;
            m_t = 0; m_streak = 0; m_hold_edges = 0;
        end else begin
            m_ls   = ms2;
            m_soft = bus.soft_rst_req;
            if (m_wait) begin
                if (m_hold_edges == WC - 1) m_wdog = 1;
                if (m_hold_edges < 1000000) m_hold_edges++;
            end else begin
                m_hold_edges = 0;
            end
            if (m_gap) begin
                m_gap = 0; m_wait = 1; m_streak = 0;
            end else if (m_wait) begin
                if (!m_ls || m_soft) m_streak = 0;
                else if (m_streak == LF - 1) begin m_wait = 0; m_t = 0; end
                else m_streak++;
            end else if (!m_ls || m_soft) begin
                m_gap = 1;
            end else begin
                if (m_t < 1000000) m_t++;
                if (m_t == SD * NS) m_wdog = 0;
            end
            ms2 = ms1;
            ms1 = bus.pll_locked;
        end
    end

    function automatic logic [NS-1:0] exp_stages();
        int n;
        if (m_wait || m_gap) return '0;
        n = m_t / SD;
        if (n > NS) n = NS;
        return NS'((1 << n) - 1);
    endfunction

    function automatic logic exp_ready();
        return !m_wait && !m_gap && (m_t > SD * NS);
    endfunction

    function automatic logic exp_wdog();
`ifdef RSTSEQ_WDOG_EN
        return m_wdog;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        check("cyc_stage_rst_n", {29'b0, bus.stage_rst_n}, {29'b0, exp_stages()});
        check("cyc_all_ready", {31'b0, bus.all_ready}, {31'b0, exp_ready()});
        check("cyc_busy", {31'b0, bus.busy}, {31'b0, !exp_ready()});
        check("cyc_wdog", {31'b0, bus.wdog_timeout}, {31'b0, exp_wdog()});
    end

    int t1, t2, t3, tr;

    task automatic wait_ready(input string name);
        for (int unsigned c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.all_ready === 1'b1) break;
        end
        check(name, {31'b0, bus.all_ready}, 32'd1);
    endtask

    task automatic time_stage0(input string name);
        t1 = -1;
        for (int unsigned c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.stage_rst_n === 3'b001 && t1 < 0) t1 = int'(c);
        end
        check(name, t1, 32'd26);
    endtask

    initial begin
        bus.pll_locked   = 1'b0;
        bus.soft_rst_req = 1'b0;
        rst_n            = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_stage", {29'b0, bus.stage_rst_n}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd1);
        check("rst_ready", {31'b0, bus.all_ready}, 32'd0);

        // Power-on lock
        #1 rst_n = 1'b1; bus.pll_locked = 1'b1;
        t1 = -1; t2 = -1; t3 = -1; tr = -1;
        for (int unsigned c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (bus.stage_rst_n === 3'b001 && t1 < 0) t1 = int'(c);
            if (bus.stage_rst_n === 3'b011 && t2 < 0) t2 = int'(c);
            if (bus.stage_rst_n === 3'b111 && t3 < 0) t3 = int'(c);
            if (bus.all_ready === 1'b1 && tr < 0) tr = int'(c);
        end
        check("pwr_stage0_t", t1, 32'd26);
        check("pwr_stage1_t", t2, 32'd42);
        check("pwr_stage2_t", t3, 32'd58);
        check("pwr_ready_t", tr, 32'd59);

        // Lock loss in RUN
        #1 bus.pll_locked = 1'b0;
        for (int unsigned c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 2) check("loss_sync_hold", {29'b0, bus.stage_rst_n}, 32'd7);
            if (c == 3) begin
                check("loss_stage", {29'b0, bus.stage_rst_n}, 32'd0);
                check("loss_ready", {31'b0, bus.all_ready}, 32'd0);
            end
        end
        repeat (6) @(negedge clk);

        // One-cycle lock glitch at filter count 5
        #1 bus.pll_locked = 1'b1;
        t1 = -1;
        for (int unsigned c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.stage_rst_n === 3'b001 && t1 < 0) t1 = int'(c);
            if (c == 5) #1 bus.pll_locked = 1'b0;
            if (c == 6) #1 bus.pll_locked = 1'b1;
        end
        check("glitch_stage0_t", t1, 32'd32);
        wait_ready("glitch_ready");

        // Soft request from RUN, then again during RELEASE
        @(negedge clk);
        #1 bus.soft_rst_req = 1'b1;
        @(negedge clk);
        check("soft_run_stage", {29'b0, bus.stage_rst_n}, 32'd0);
        check("soft_run_busy", {31'b0, bus.busy}, 32'd1);
        #1 bus.soft_rst_req = 1'b0;
        t1 = -1;
        for (int unsigned c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (bus.stage_rst_n === 3'b001 && t1 < 0) t1 = int'(c);
        end
        check("soft_rerun_stage0_t", t1, 32'd26);
        #1 bus.soft_rst_req = 1'b1;
        @(negedge clk);
        check("soft_rel_stage", {29'b0, bus.stage_rst_n}, 32'd0);
        check("soft_rel_busy", {31'b0, bus.busy}, 32'd1);
        #1 bus.soft_rst_req = 1'b0;

        // Async reset while stage_rst_n = 3'b011
        for (int unsigned c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.stage_rst_n === 3'b011) break;
        end
        check("arst_pre_stage", {29'b0, bus.stage_rst_n}, 32'd3);
        #3 rst_n = 1'b0;
        #1;
        check("arst_stage", {29'b0, bus.stage_rst_n}, 32'd0);
        check("arst_ready", {31'b0, bus.all_ready}, 32'd0);
        check("arst_busy", {31'b0, bus.busy}, 32'd1);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        time_stage0("arst_restart_stage0_t");
        wait_ready("arst_ready_again");

        // Watchdog: no lock after reset
        @(negedge clk);
        #1 rst_n = 1'b0; bus.pll_locked = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        t1 = -1;
        for (int unsigned c = 1; c <= 130; c++) begin
            @(negedge clk);
            if (bus.wdog_timeout === 1'b1 && t1 < 0) t1 = int'(c);
        end
        check("wdog_set_t", t1, WD_EXP_T);
        check("wdog_sticky", {31'b0, bus.wdog_timeout}, {31'b0, WD_EXP_T > 0});
        #1 bus.pll_locked = 1'b1;
        wait_ready("wdog_lock_ready");
        check("wdog_cleared", {31'b0, bus.wdog_timeout}, 32'd0);

        // Random stress against the model
        for (int unsigned i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 999) < 8) bus.pll_locked = ~bus.pll_locked;
            bus.soft_rst_req = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        bus.soft_rst_req = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
